// File: rtl/regfile_pkg.sv
// Shared types and default widths for the CPU register file, ALU and decoder.
package regfile_pkg;

  typedef enum logic {
    RF_IDLE  = 1'b0,
    RF_CLEAR = 1'b1
  } rf_state_t;

  localparam int RF_DATA_W = 4;
  localparam int RF_ADDR_W = 3;

endpackage

// File: rtl/regfile_clear_seq.sv
// Clear sequencer: walks every register-file entry once, one per cycle, then
// pulses clear_done.
//
// state    | meaning
// RF_IDLE  | normal operation, writes accepted, waiting for clear_req
// RF_CLEAR | zeroing entry cnt_q this cycle, writes dropped
module regfile_clear_seq
  import regfile_pkg::*;
#(
  parameter int ADDR_W = RF_ADDR_W
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              clear_req,
  output logic              clear_busy,
  output logic              clear_we,
  output logic [ADDR_W-1:0] clear_addr,
  output logic              clear_done
);

  localparam logic [ADDR_W-1:0] LAST_ADDR = '1;

  rf_state_t         state_q, state_d;
  logic [ADDR_W-1:0] cnt_q, cnt_d;
  logic              done_q, done_d;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= RF_IDLE;
      cnt_q   <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      done_q  <= done_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    done_d  = 1'b0;
    case (state_q)
      RF_IDLE: begin
        if (clear_req) begin
          state_d = RF_CLEAR;
          cnt_d   = '0;
        end
      end
      RF_CLEAR: begin
        cnt_d = cnt_q + 1'b1;
        // clear_req is deliberately not looked at here: no restart or extension
        if (cnt_q == LAST_ADDR) begin
          state_d = RF_IDLE;
          cnt_d   = '0;
          done_d  = 1'b1;
        end
      end
      default: begin
        state_d = RF_IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  assign clear_busy = (state_q == RF_CLEAR);
  assign clear_we   = clear_busy;
  assign clear_addr = cnt_q;
  assign clear_done = done_q;

endmodule

// File: rtl/multiport_register_file.sv
// Register file between decode and ALU: NUM_RD registered read ports, one
// write port, optional write-to-read bypass and hardwired-zero entry 0.
module multiport_register_file
  import regfile_pkg::*;
#(
  parameter int DATA_W   = RF_DATA_W,
  parameter int ADDR_W   = RF_ADDR_W,
  parameter int NUM_RD   = 2,
  parameter int ZERO_REG = 0,
  parameter int BYPASS   = 1
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     wr_en,
  input  logic [ADDR_W-1:0]        wr_addr,
  input  logic [DATA_W-1:0]        wr_data,
  output logic                     wr_ready,
  input  logic [NUM_RD*ADDR_W-1:0] rd_addr,
  output logic [NUM_RD*DATA_W-1:0] rd_data,
  input  logic                     clear_req,
  output logic                     clear_busy,
  output logic                     clear_done
);

  localparam int DEPTH = 2 ** ADDR_W;

  logic [DATA_W-1:0]        mem_q [DEPTH];
  logic [DATA_W-1:0]        mem_d [DEPTH];
  logic [NUM_RD*DATA_W-1:0] rd_q, rd_d;
  logic                     clear_we;
  logic [ADDR_W-1:0]        clear_addr;
  logic                     wr_acc;
  logic                     wr_commit;

  regfile_clear_seq #(.ADDR_W(ADDR_W)) u_clear_seq (
    .clk        (clk),
    .reset      (reset),
    .clear_req  (clear_req),
    .clear_busy (clear_busy),
    .clear_we   (clear_we),
    .clear_addr (clear_addr),
    .clear_done (clear_done)
  );

  assign wr_ready  = ~clear_busy;
  assign wr_acc    = wr_en & wr_ready;
  assign wr_commit = wr_acc & ~((ZERO_REG != 0) && (wr_addr == '0));

  always_comb begin
    mem_d = mem_q;
    if (clear_we) begin
      mem_d[clear_addr] = '0;
    end else if (wr_commit) begin
      mem_d[wr_addr] = wr_data;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
    end else begin
      mem_q <= mem_d;
    end
  end

  // While clearing, the file reads as empty even for entries not yet reached.
  always_comb begin : read_mux
    logic [ADDR_W-1:0] ra;
    logic [DATA_W-1:0] val;
    rd_d = '0;
    ra   = '0;
    val  = '0;
    if (!clear_busy) begin
      for (int i = 0; i < NUM_RD; i++) begin
        ra  = rd_addr[i*ADDR_W +: ADDR_W];
        val = mem_q[ra];
        if ((BYPASS != 0) && wr_acc && (wr_addr == ra)) begin
          val = wr_data;
        end
        if ((ZERO_REG != 0) && (ra == '0)) begin
          val = '0;
        end
        rd_d[i*DATA_W +: DATA_W] = val;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rd_q <= '0;
    end else begin
      rd_q <= rd_d;
    end
  end

  assign rd_data = rd_q;

endmodule

// File: tb/tb_multiport_register_file.sv
// Bench for multiport_register_file: default, no-bypass and zero-register
// instances share one stimulus stream and are checked side by side.
module tb_multiport_register_file;

  logic       clk = 1'b0;
  logic       reset;
  logic       wr_en;
  logic [2:0] wr_addr;
  logic [3:0] wr_data;
  logic [5:0] rd_addr;
  logic       clear_req;

  logic [7:0] rd_def, rd_nb, rd_z;
  logic       rdy_def, rdy_nb, rdy_z;
  logic       busy_def, busy_nb, busy_z;
  logic       done_def, done_nb, done_z;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  multiport_register_file #(.ZERO_REG(0), .BYPASS(1)) dut (
    .clk(clk), .reset(reset), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .wr_ready(rdy_def), .rd_addr(rd_addr), .rd_data(rd_def), .clear_req(clear_req),
    .clear_busy(busy_def), .clear_done(done_def)
  );

  multiport_register_file #(.ZERO_REG(0), .BYPASS(0)) dut_nb (
    .clk(clk), .reset(reset), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .wr_ready(rdy_nb), .rd_addr(rd_addr), .rd_data(rd_nb), .clear_req(clear_req),
    .clear_busy(busy_nb), .clear_done(done_nb)
  );

  multiport_register_file #(.ZERO_REG(1), .BYPASS(1)) dut_z (
    .clk(clk), .reset(reset), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .wr_ready(rdy_z), .rd_addr(rd_addr), .rd_data(rd_z), .clear_req(clear_req),
    .clear_busy(busy_z), .clear_done(done_z)
  );

  typedef struct {
    logic       we;
    logic [2:0] wa;
    logic [3:0] wd;
    logic [2:0] ra0;
    logic [2:0] ra1;
    logic [3:0] d0, d1;
    logic [3:0] n0, n1;
    logic [3:0] z0, z1;
  } vec_t;

  typedef struct {
    string      nm;
    logic [7:0] d;
    logic [7:0] n;
    logic [7:0] z;
  } exp_t;

  vec_t vecs [12];
  exp_t sb [$];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic sb_push(input string nm, input logic [7:0] d, input logic [7:0] n,
                         input logic [7:0] z);
    exp_t e;
    e.nm = nm;
    e.d  = d;
    e.n  = n;
    e.z  = z;
    sb.push_back(e);
  endtask

  task automatic sb_check();
    exp_t e;
    if (sb.size() == 0) begin
      chk("scoreboard_empty", 32'd1, 32'd0);
    end else begin
      e = sb.pop_front();
      chk({e.nm, "_def"}, {24'd0, rd_def}, {24'd0, e.d});
      chk({e.nm, "_nb"},  {24'd0, rd_nb},  {24'd0, e.n});
      chk({e.nm, "_z"},   {24'd0, rd_z},   {24'd0, e.z});
    end
  endtask

  task automatic sweep_zero(input string nm);
    for (int a = 0; a < 8; a++) begin
      rd_addr = {3'(7 - a), 3'(a)};
      sb_push(nm, 8'h00, 8'h00, 8'h00);
      tick();
      sb_check();
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int busy_n, done_n, done_at;
    logic zero_ok, ready_ok;

    vecs[0]  = '{1'b0, 3'd0, 4'h0, 3'd0, 3'd7, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0};
    vecs[1]  = '{1'b1, 3'd3, 4'h5, 3'd0, 3'd1, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0};
    vecs[2]  = '{1'b0, 3'd0, 4'h0, 3'd3, 3'd3, 4'h5, 4'h5, 4'h5, 4'h5, 4'h5, 4'h5};
    vecs[3]  = '{1'b1, 3'd7, 4'hF, 3'd3, 3'd0, 4'h5, 4'h0, 4'h5, 4'h0, 4'h5, 4'h0};
    vecs[4]  = '{1'b1, 3'd0, 4'hA, 3'd7, 3'd4, 4'hF, 4'h0, 4'hF, 4'h0, 4'hF, 4'h0};
    vecs[5]  = '{1'b0, 3'd0, 4'h0, 3'd0, 3'd7, 4'hA, 4'hF, 4'hA, 4'hF, 4'h0, 4'hF};
    vecs[6]  = '{1'b1, 3'd2, 4'h9, 3'd5, 3'd2, 4'h0, 4'h9, 4'h0, 4'h0, 4'h0, 4'h9};
    vecs[7]  = '{1'b0, 3'd0, 4'h0, 3'd2, 3'd2, 4'h9, 4'h9, 4'h9, 4'h9, 4'h9, 4'h9};
    vecs[8]  = '{1'b1, 3'd0, 4'hC, 3'd0, 3'd0, 4'hC, 4'hC, 4'hA, 4'hA, 4'h0, 4'h0};
    vecs[9]  = '{1'b0, 3'd0, 4'h0, 3'd0, 3'd3, 4'hC, 4'h5, 4'hC, 4'h5, 4'h0, 4'h5};
    vecs[10] = '{1'b1, 3'd3, 4'h6, 3'd3, 3'd3, 4'h6, 4'h6, 4'h5, 4'h5, 4'h6, 4'h6};
    vecs[11] = '{1'b0, 3'd0, 4'h0, 3'd3, 3'd2, 4'h6, 4'h9, 4'h6, 4'h9, 4'h6, 4'h9};

    reset     = 1'b1;
    wr_en     = 1'b0;
    wr_addr   = '0;
    wr_data   = '0;
    rd_addr   = '0;
    clear_req = 1'b0;
    #7;
    reset = 1'b0;
    chk("reset_wr_ready", 32'(rdy_def), 32'd1);
    chk("reset_clear_busy", 32'(busy_def), 32'd0);
    chk("reset_clear_done", 32'(done_def), 32'd0);
    chk("reset_rd_data", 32'(rd_def), 32'd0);

    // Put a value in entry 1 and read it out, then reset asynchronously mid-cycle.
    wr_en = 1'b1; wr_addr = 3'd1; wr_data = 4'hF;
    tick();
    wr_en = 1'b0; rd_addr = {3'd1, 3'd1};
    tick();
    chk("pre_reset_read", 32'(rd_def), 32'hFF);
    #3;
    reset = 1'b1;
    #1;
    chk("async_reset_rd_data", 32'(rd_def), 32'd0);
    chk("async_reset_wr_ready", 32'(rdy_def), 32'd1);
    chk("async_reset_busy", 32'(busy_def), 32'd0);
    #2;
    reset = 1'b0;
    sweep_zero("post_reset_read");

    for (int v = 0; v < 12; v++) begin
      wr_en   = vecs[v].we;
      wr_addr = vecs[v].wa;
      wr_data = vecs[v].wd;
      rd_addr = {vecs[v].ra1, vecs[v].ra0};
      sb_push($sformatf("vec%0d", v), {vecs[v].d1, vecs[v].d0},
              {vecs[v].n1, vecs[v].n0}, {vecs[v].z1, vecs[v].z0});
      tick();
      sb_check();
    end
    wr_en = 1'b0;

    // Clear sequence: fill 1..8, clear, re-request and write mid-sequence.
    for (int a = 0; a < 8; a++) begin
      wr_en = 1'b1; wr_addr = 3'(a); wr_data = 4'(a + 1);
      tick();
    end
    wr_en = 1'b0;
    rd_addr = {3'd0, 3'd7};
    sb_push("fill_read", 8'h18, 8'h18, 8'h08);
    tick();
    sb_check();

    clear_req = 1'b1;
    rd_addr   = {3'd2, 3'd4};
    tick();
    clear_req = 1'b0;
    busy_n = 0; done_n = 0; done_at = -1; zero_ok = 1'b1; ready_ok = 1'b1;
    for (int i = 0; i < 16; i++) begin
      if (busy_def) busy_n++;
      if (done_def) begin
        done_n++;
        done_at = i;
      end
      if (rdy_def !== ~busy_def) ready_ok = 1'b0;
      if (i >= 1 && i <= 8 && (rd_def !== 8'h00 || rd_nb !== 8'h00 || rd_z !== 8'h00))
        zero_ok = 1'b0;
      if (i == 3) begin
        clear_req = 1'b1; wr_en = 1'b1; wr_addr = 3'd4; wr_data = 4'h7;
      end
      if (i == 4) begin
        clear_req = 1'b0; wr_en = 1'b0;
      end
      tick();
    end
    chk("clear_busy_cycles", 32'(busy_n), 32'd8);
    chk("clear_done_pulses", 32'(done_n), 32'd1);
    chk("clear_done_position", 32'(done_at), 32'd8);
    chk("clear_reads_zero", 32'(zero_ok), 32'd1);
    chk("clear_wr_ready", 32'(ready_ok), 32'd1);
    chk("clear_busy_nb", 32'(busy_nb), 32'd0);
    sweep_zero("after_clear");

    // Reset in the third busy cycle aborts the clear with no done pulse.
    wr_en = 1'b1; wr_addr = 3'd6; wr_data = 4'h3;
    tick();
    wr_en = 1'b0; clear_req = 1'b1;
    tick();
    clear_req = 1'b0;
    tick();
    tick();
    chk("mid_clear_busy", 32'(busy_def), 32'd1);
    #3;
    reset = 1'b1;
    #1;
    chk("abort_busy", 32'(busy_def), 32'd0);
    chk("abort_wr_ready", 32'(rdy_def), 32'd1);
    chk("abort_done", 32'(done_def), 32'd0);
    chk("abort_rd_data", 32'(rd_def), 32'd0);
    #2;
    reset = 1'b0;
    done_n = 0;
    for (int i = 0; i < 10; i++) begin
      tick();
      if (done_def) done_n++;
    end
    chk("abort_no_done", 32'(done_n), 32'd0);
    sweep_zero("after_abort");

    wr_en = 1'b1; wr_addr = 3'd5; wr_data = 4'h3;
    tick();
    wr_en = 1'b0; rd_addr = {3'd5, 3'd5};
    sb_push("post_abort_write", 8'h33, 8'h33, 8'h33);
    tick();
    sb_check();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
